// File: rtl/ahb_lite_arbiter.sv
// rtl/ahb_lite_arbiter.sv - round-robin AHB-Lite bus arbiter with lock and hold limit
//
// Purpose:
//   Shares one AHB-Lite slave-side bus among NUM_MASTERS masters. Grants the
//   address phase to one master at a time, tracks address- and data-phase
//   ownership, honours HLOCK for the current grantee and forces rotation after
//   MAX_HOLD counted transfers when another master is waiting.
//
// Ports:
//   HCLK       in   bus clock, rising edge
//   HRESET     in   synchronous active-high reset (overrides HREADY)
//   HBUSREQ    in   per-master request, level-sensitive
//   HLOCK      in   per-master lock request, honoured for the grantee only
//   HTRANS     in   muxed HTRANS of the current address-phase owner
//   HREADY     in   bus ready; low freezes all arbiter state
//   HGRANT     out  one-hot grant, registered
//   HMASTER    out  address-phase owner index, registered
//   HMASTER_D  out  data-phase owner index, registered
//   HMASTLOCK  out  current address phase is locked, registered

module ahb_lite_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MW             = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 4
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic [MW-1:0]          HMASTER_D,
  output logic                   HMASTLOCK
);

  typedef enum logic {
    ST_PARK = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  localparam logic [NUM_MASTERS-1:0] ONE_BIT = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          owner_q, owner_d;     // index form of grant_q
  logic [MW-1:0]          hmaster_q, hmaster_d;
  logic [MW-1:0]          data_master_q, data_master_d;
  logic                   hmastlock_q, hmastlock_d;
  logic [3:0]             hold_cnt_q, hold_cnt_d;
  logic [MW-1:0]          rr_ptr_q, rr_ptr_d;

  logic                   other_req;
  logic                   owner_req;
  logic                   owner_lock;
  logic                   rr_found;
  logic [MW-1:0]          rr_cand;
  logic [MW-1:0]          next_owner;
  logic                   grant_change;
  logic                   xfer_counted;
  int                     idx;

  // Circular search starting just after rr_ptr; the current owner sits at
  // the end of the search order, so it is picked only if nobody else asks.
  always_comb begin
    rr_found = 1'b0;
    rr_cand  = DEF_IDX;
    idx      = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_MASTERS;
      if (!rr_found && ((HBUSREQ & (ONE_BIT << idx)) != '0)) begin
        rr_found = 1'b1;
        rr_cand  = MW'(idx);
      end
    end
  end

  always_comb begin
    other_req  = (HBUSREQ & ~grant_q) != '0;
    owner_req  = HBUSREQ[owner_q];
    owner_lock = HLOCK[owner_q];

    if (owner_lock) begin
      next_owner = owner_q;
    end else if (owner_req && (!other_req || (int'(hold_cnt_q) < MAX_HOLD))) begin
      next_owner = owner_q;
    end else if (rr_found) begin
      next_owner = rr_cand;
    end else begin
      next_owner = DEF_IDX;
    end

    grant_change = (next_owner != owner_q);
    // Only NONSEQ/SEQ from the owner's own address phase count; the first
    // cycle after a handover still carries the previous master's transfer.
    xfer_counted = ((HTRANS == 2'b10) || (HTRANS == 2'b11)) && (hmaster_q == owner_q);
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    hmaster_d     = hmaster_q;
    data_master_d = data_master_q;
    hmastlock_d   = hmastlock_q;
    hold_cnt_d    = hold_cnt_q;
    rr_ptr_d      = rr_ptr_q;

    if (HREADY) begin
      owner_d       = next_owner;
      grant_d       = ONE_BIT << next_owner;
      hmaster_d     = owner_q;
      data_master_d = hmaster_q;
      hmastlock_d   = owner_lock;

      if (grant_change) begin
        rr_ptr_d   = next_owner;
        hold_cnt_d = 4'd0;
      end else if (xfer_counted && (hold_cnt_q != 4'd15)) begin
        hold_cnt_d = hold_cnt_q + 4'd1;
      end

      case (state_q)
        ST_PARK: if (HBUSREQ != '0) state_d = ST_OWN;
        ST_OWN:  if ((HBUSREQ == '0) && !owner_lock) state_d = ST_PARK;
        default: state_d = ST_PARK;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q       <= ST_PARK;
      grant_q       <= ONE_BIT << DEF_IDX;
      owner_q       <= DEF_IDX;
      hmaster_q     <= DEF_IDX;
      data_master_q <= DEF_IDX;
      hmastlock_q   <= 1'b0;
      hold_cnt_q    <= 4'd0;
      rr_ptr_q      <= DEF_IDX;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      hmaster_q     <= hmaster_d;
      data_master_q <= data_master_d;
      hmastlock_q   <= hmastlock_d;
      hold_cnt_q    <= hold_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTER_D = data_master_q;
  assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// tb/tb_ahb_lite_arbiter.sv - self-checking bench for ahb_lite_arbiter

module tb_ahb_lite_arbiter;

  localparam int N   = 4;
  localparam int MWL = 2;
  localparam int DEF = 0;
  localparam int MH  = 4;

  logic           HCLK = 1'b0;
  logic           HRESET;
  logic [N-1:0]   HBUSREQ;
  logic [N-1:0]   HLOCK;
  logic [1:0]     HTRANS;
  logic           HREADY;
  logic [N-1:0]   HGRANT;
  logic [MWL-1:0] HMASTER;
  logic [MWL-1:0] HMASTER_D;
  logic           HMASTLOCK;

  always #5 HCLK = ~HCLK;

  ahb_lite_arbiter #(
    .NUM_MASTERS(N), .MW(MWL), .DEFAULT_MASTER(DEF), .MAX_HOLD(MH)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HREADY(HREADY), .HGRANT(HGRANT), .HMASTER(HMASTER),
    .HMASTER_D(HMASTER_D), .HMASTLOCK(HMASTLOCK)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: owner index, round-robin pointer, hold count,
  // address/data phase owners and registered lock.
  int m_g, m_rr, m_hold, m_ms, m_md, m_lk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lck;
    logic [1:0] trans;
    logic       rdy;
    logic [3:0] e_grant;
    int         e_master;
    int         e_master_d;
    logic       e_lock;
  } vec_t;

  vec_t tbl[17];

  function automatic int bit_of(input logic [3:0] v, input int i);
    return ((v >> i) & 4'd1) != 4'd0 ? 1 : 0;
  endfunction

  function automatic int pick(input logic [3:0] req, input logic [3:0] lk);
    int others;
    int k_idx;
    if (bit_of(lk, m_g) != 0) return m_g;
    others = 0;
    for (int i = 0; i < N; i++)
      if (i != m_g && bit_of(req, i) != 0) others = 1;
    if (bit_of(req, m_g) != 0 && (others == 0 || m_hold < MH)) return m_g;
    for (int k = 1; k <= N; k++) begin
      k_idx = (m_rr + k) % N;
      if (bit_of(req, k_idx) != 0) return k_idx;
    end
    return DEF;
  endfunction

  task automatic model_edge(input logic rst, input logic [3:0] req, input logic [3:0] lk,
                            input logic [1:0] tr, input logic rdy);
    int nxt;
    int nh;
    if (rst) begin
      m_g = DEF; m_rr = DEF; m_hold = 0; m_ms = DEF; m_md = DEF; m_lk = 0;
    end else if (rdy) begin
      nxt = pick(req, lk);
      if (nxt != m_g) nh = 0;
      else if (tr[1] && m_ms == m_g) nh = (m_hold < 15) ? m_hold + 1 : 15;
      else nh = m_hold;
      m_md = m_ms;
      m_ms = m_g;
      m_lk = bit_of(lk, m_g);
      if (nxt != m_g) m_rr = nxt;
      m_g = nxt;
      m_hold = nh;
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] lk,
                       input logic [1:0] tr, input logic rdy);
    HRESET  = rst;
    HBUSREQ = req;
    HLOCK   = lk;
    HTRANS  = tr;
    HREADY  = rdy;
    model_edge(rst, req, lk, tr, rdy);
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_grant"},    int'(HGRANT),    1 << m_g);
    chk({tag, "_master"},   int'(HMASTER),   m_ms);
    chk({tag, "_master_d"}, int'(HMASTER_D), m_md);
    chk({tag, "_lock"},     int'(HMASTLOCK), m_lk);
    chk({tag, "_onehot"},   $onehot(HGRANT) ? 1 : 0, 1);
  endtask

  initial begin
    logic [3:0] r_req, r_lck;
    logic [1:0] r_tr;
    logic       r_rst, r_rdy;

    // Reset, park, park-to-M2 latency, return to park, then HREADY stall.
    tbl[0]  = '{1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 4'h1, 0, 0, 1'b0};
    tbl[1]  = '{1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 4'h1, 0, 0, 1'b0};
    tbl[2]  = '{1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 4'h1, 0, 0, 1'b0};
    tbl[3]  = '{1'b0, 4'h4, 4'h0, 2'b00, 1'b1, 4'h4, 0, 0, 1'b0};
    tbl[4]  = '{1'b0, 4'h4, 4'h0, 2'b00, 1'b1, 4'h4, 2, 0, 1'b0};
    tbl[5]  = '{1'b0, 4'h4, 4'h0, 2'b00, 1'b1, 4'h4, 2, 2, 1'b0};
    tbl[6]  = '{1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 4'h1, 2, 2, 1'b0};
    tbl[7]  = '{1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 4'h1, 0, 2, 1'b0};
    tbl[8]  = '{1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 4'h1, 0, 0, 1'b0};
    tbl[9]  = '{1'b0, 4'h2, 4'h0, 2'b00, 1'b1, 4'h2, 0, 0, 1'b0};
    tbl[10] = '{1'b0, 4'h2, 4'h0, 2'b00, 1'b1, 4'h2, 1, 0, 1'b0};
    for (int i = 11; i <= 15; i++)
      tbl[i] = '{1'b0, 4'h8, 4'h0, 2'b00, 1'b0, 4'h2, 1, 0, 1'b0};
    tbl[16] = '{1'b0, 4'h8, 4'h0, 2'b00, 1'b1, 4'h8, 1, 1, 1'b0};

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].lck, tbl[i].trans, tbl[i].rdy);
      chk($sformatf("tbl%0d_grant", i),    int'(HGRANT),    int'(tbl[i].e_grant));
      chk($sformatf("tbl%0d_master", i),   int'(HMASTER),   tbl[i].e_master);
      chk($sformatf("tbl%0d_master_d", i), int'(HMASTER_D), tbl[i].e_master_d);
      chk($sformatf("tbl%0d_lock", i),     int'(HMASTLOCK), int'(tbl[i].e_lock));
      chk_model("tbl_model");
    end

    // M1 and M3 contend with NONSEQ every cycle: each tenure lasts 6 grant
    // cycles (one handover bubble + 4 counted + the switching edge).
    drive(1'b1, 4'h0, 4'h0, 2'b00, 1'b1);
    drive(1'b1, 4'h0, 4'h0, 2'b00, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      drive(1'b0, 4'b1010, 4'h0, 2'b10, 1'b1);
      chk($sformatf("rr_grant_k%0d", k), int'(HGRANT), (((k - 1) / 6) % 2 == 0) ? 2 : 8);
      chk_model("rr_model");
    end

    // M0 locked while M2 waits; 10 NONSEQ transfers keep the grant on M0.
    drive(1'b1, 4'h0, 4'h0, 2'b00, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 4'b0101, 4'b0001, 2'b10, 1'b1);
      chk($sformatf("lock_grant_k%0d", k), int'(HGRANT), 1);
      chk($sformatf("lock_mastlock_k%0d", k), int'(HMASTLOCK), 1);
      chk_model("lock_model");
    end
    drive(1'b0, 4'b0101, 4'b0000, 2'b10, 1'b1);
    chk("unlock_grant", int'(HGRANT), 4);
    chk("unlock_mastlock", int'(HMASTLOCK), 0);
    chk_model("unlock_model");

    // Move to M3, then reset with HREADY low mid-tenure.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'b1000, 4'h0, 2'b10, 1'b1);
      chk_model("m3_model");
    end
    chk("m3_grant", int'(HGRANT), 8);
    drive(1'b1, 4'b1000, 4'h0, 2'b10, 1'b0);
    chk("rst_grant", int'(HGRANT), 1);
    chk("rst_master", int'(HMASTER), 0);
    chk("rst_master_d", int'(HMASTER_D), 0);
    chk("rst_lock", int'(HMASTLOCK), 0);
    chk_model("rst_model");

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      r_rst = ($urandom_range(0, 49) == 0);
      r_req = 4'($urandom);
      r_lck = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      r_tr  = 2'($urandom);
      r_rdy = ($urandom_range(0, 4) != 0);
      drive(r_rst, r_req, r_lck, r_tr, r_rdy);
      chk_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
